// File: rtl/ccc_fabric_clkgen_pkg.sv
// Shared types and helpers for the fabric clock-enable generator.
// Config fields are held at a fixed maximum width; DIV_W must not exceed CfgW.
package ccc_clkgen_pkg;

  localparam int unsigned CfgW = 16;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StPend,
    StSettle
  } clkgen_state_e;

  typedef struct packed {
    logic [CfgW-1:0] div;
    logic [CfgW-1:0] phase;
    logic            en;
  } chan_cfg_t;

  // A phase beyond the period end starts the channel on its last count.
  function automatic logic [CfgW-1:0] eff_phase(input logic [CfgW-1:0] div,
                                                input logic [CfgW-1:0] phase);
    return (phase > div) ? div : phase;
  endfunction

  // Number of counts per period for which gl is high: (div + 2) >> 1.
  function automatic logic [CfgW-1:0] hi_count(input logic [CfgW-1:0] div);
    logic [CfgW:0] sum;
    sum = {1'b0, div} + (CfgW + 1)'(2);
    return sum[CfgW:1];
  endfunction

endpackage

// File: rtl/ccc_fabric_clkgen_if.sv
// Configuration valid/ready channel into the fabric clock-enable generator.
interface ccc_fabric_clkgen_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIV_W  = 5
) ();

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [ChW-1:0]   cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_en;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_phase,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_phase,
    input  cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/ccc_fabric_clkgen_chan.sv
// One divider channel: period counter plus registered ce/gl derived from the counter state.
module ccc_clkgen_chan
  import ccc_clkgen_pkg::*;
#(
  parameter int unsigned DIV_W       = 5,
  parameter int unsigned DEFAULT_DIV = 3,
  parameter bit          DEFAULT_EN  = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      run,
  input  logic      load,
  input  logic      apply,
  input  chan_cfg_t new_cfg,
  output logic      en,
  output logic      wrap,
  output logic      ce,
  output logic      gl
);

  chan_cfg_t        cfg_q, cfg_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             start;
  logic             active;
  logic             ce_d, gl_d;

  assign start = load | apply;

  // ce/gl are computed from the next count so they line up with cnt_q in the same cycle.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    if (apply) begin
      cfg_d = new_cfg;
    end
    if (!cfg_d.en || !(run || start)) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = DIV_W'(eff_phase(cfg_d.div, cfg_d.phase));
    end else if (CfgW'(cnt_q) == cfg_q.div) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    active = cfg_d.en & (run | start);
    ce_d   = active & (cnt_d == '0);
    gl_d   = active & (CfgW'(cnt_d) < hi_count(cfg_d.div));
  end

  assign en   = cfg_q.en;
  assign wrap = cfg_q.en & run & (CfgW'(cnt_q) == cfg_q.div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= '{div: CfgW'(DEFAULT_DIV), phase: '0, en: DEFAULT_EN};
      cnt_q <= '0;
      ce    <= 1'b0;
      gl    <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ce    <= ce_d;
      gl    <= gl_d;
    end
  end

endmodule

// File: rtl/ccc_fabric_clkgen.sv
// Multi-channel fabric clock-enable / divided-clock generator with glitch-free
// reconfiguration on the target channel's period boundary.
module ccc_fabric_clkgen
  import ccc_clkgen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 5,
  parameter int unsigned DEFAULT_DIV = 3,
  parameter bit          DEFAULT_EN  = 1'b1,
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic                CLKA,
  input  logic                RESET,
  ccc_fabric_clkgen_if.slave  cfg,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   gl,
  output logic                lock
);

  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SetW = $clog2(LOCK_CYCLES + 1);
  localparam logic [SetW-1:0] SetLast = SetW'(LOCK_CYCLES - 1);

  clkgen_state_e    state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  chan_cfg_t        shadow_q, shadow_d;
  logic [ChW-1:0]   sch_q, sch_d;

  logic              run, load, apply, ready;
  logic              in_range;
  logic [NUM_CH-1:0] chan_en, chan_wrap, apply_vec;

  assign run      = (state_q != StInit);
  assign in_range = (int'(cfg.cfg_ch) < int'(NUM_CH));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    sch_d    = sch_q;
    load     = 1'b0;
    apply    = 1'b0;
    ready    = 1'b0;
    lock     = 1'b0;
    unique case (state_q)
      StInit: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetLast) begin
          state_d  = StRun;
          settle_d = '0;
          load     = 1'b1;
        end
      end
      StRun: begin
        ready = 1'b1;
        lock  = 1'b1;
        // Out-of-range channel numbers are accepted and dropped.
        if (cfg.cfg_valid && in_range) begin
          shadow_d = '{div: CfgW'(cfg.cfg_div), phase: CfgW'(cfg.cfg_phase), en: cfg.cfg_en};
          sch_d    = cfg.cfg_ch;
          state_d  = StPend;
        end
      end
      StPend: begin
        if (!chan_en[sch_q] || chan_wrap[sch_q]) begin
          apply    = 1'b1;
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetLast) begin
          state_d  = StRun;
          settle_d = '0;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign cfg.cfg_ready = ready;

  always_ff @(posedge CLKA or posedge RESET) begin
    if (RESET) begin
      state_q  <= StInit;
      settle_q <= '0;
      shadow_q <= '0;
      sch_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      sch_q    <= sch_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign apply_vec[i] = apply & (sch_q == ChW'(i));

    ccc_clkgen_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_EN  (DEFAULT_EN)
    ) u_chan (
      .clk     (CLKA),
      .rst     (RESET),
      .run     (run),
      .load    (load),
      .apply   (apply_vec[i]),
      .new_cfg (shadow_q),
      .en      (chan_en[i]),
      .wrap    (chan_wrap[i]),
      .ce      (ce[i]),
      .gl      (gl[i])
    );
  end

endmodule
